instr_fetch_stage: RTL
======================

Name: instr_fetch_stage

Overview:
Parametrised instruction-fetch stage for the MIPS-style pipeline. It drives a synchronous instruction memory with 1-cycle read latency and registers the fetched instruction into the IF/ID pipeline register. It supports stall, jump and branch redirect with flush, and a one-entry skid buffer so that no fetched word is lost during a stall. The stage sits between the PC/branch-resolution logic and the decode stage.

Parameters:
ADDR_W, 32, PC and memory address width.
INSTR_W, 32, instruction width; must be at least IMM_W.
IMM_W, 16, immediate field width, taken from instr[IMM_W-1:0].
RESET_PC, 0, PC after reset; must be word-aligned.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
stall_i  in  1  decode cannot accept; hold IF/ID.
jump_i  in  1  jump redirect request.
jump_target_i  in  ADDR_W  jump destination.
branch_i  in  1  taken-branch redirect request.
branch_target_i  in  ADDR_W  branch destination.
imem_req_o  out  1  read strobe.
imem_addr_o  out  ADDR_W  read address (= PC).
imem_rdata_i  in  INSTR_W  read data, valid the cycle after the request.
if_id_valid_o  out  1  IF/ID holds a live instruction.
if_id_instr_o  out  INSTR_W  fetched instruction.
if_id_pc4_o  out  ADDR_W  address of the instruction + 4.
if_id_imm_sext_o  out  INSTR_W  sign-extended instr[IMM_W-1:0].
pc_debug_o  out  ADDR_W  current PC register.

Behaviour:
- Reset (asynchronous, any time): PC=RESET_PC, state=BOOT, all valid flags 0, skid empty, IF/ID data 0, imem_req_o=0. Any in-flight read is discarded.
- State BOOT: one cycle with no request, then RUN.
- State RUN, no redirect, no stall:
  - imem_req_o=1, imem_addr_o=PC.
  - PC<=PC+4, wrapping modulo 2^ADDR_W.
  - F2 tag (valid, pc) records the request.
- F2 data return: next cycle, imem_rdata_i is loaded into IF/ID with pc4=tag.pc+4, imm sign-extended from bit IMM_W-1, valid=1.
- Throughput: 1 instruction/cycle. First instruction after reset is valid at the 3rd rising edge after rst_n deasserts.
- Stall (stall_i=1, no redirect):
  - imem_req_o=0, PC holds, IF/ID holds all fields.
  - Returning F2 data goes into the skid buffer; the F2 tag is cleared.
  - Stall lasting many cycles: skid keeps its single entry. Only one word can be in flight, so no overflow.
- Stall release:
  - Skid non-empty: skid drains into IF/ID on that edge, and the fetch at PC issues in the same cycle.
  - Skid empty: normal flow resumes.
  - Program order is preserved.
- IF/ID with no new word: if stall_i=0 and neither F2 nor skid has data, if_id_valid_o<=0 (bubble).
- Redirect (jump_i or branch_i), priority over stall:
  - Target selection: jump_i wins over branch_i.
  - PC<=target with bits [1:0] forced to 00.
  - F2 tag and skid are invalidated; imem data returning next cycle is dropped.
  - if_id_valid_o<=0 (flush).
  - No request in the redirect cycle.
  - State REDIR for one cycle, then RUN and issue at the target.
  - Target instruction is valid in IF/ID 2 edges after REDIR, i.e. a 2-bubble penalty.
- Redirect during REDIR: the newest target wins and REDIR restarts.
- Redirect during BOOT: the target is accepted, and BOOT→REDIR.
- Stall during REDIR: no effect on the redirect sequence. Stall is then applied from RUN onward.

Optional Feature:
FETCH_PERF_EN: adds outputs perf_fetch_cnt_o[31:0] and perf_bubble_cnt_o[31:0], both reset to 0.
- perf_fetch_cnt_o increments on every IF/ID load with valid=1.
- perf_bubble_cnt_o increments on every edge where IF/ID becomes or stays invalid while stall_i=0.
- Both counters saturate at all-ones.
Without the macro: the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package if_pkg:
  - state enum {BOOT, RUN, REDIR}
  - PC_STEP=4
  - ALIGN_MASK
  - sign-extension helper function
- Sub-module if_skid_buf: one-entry holding register for {instr, pc} with load/drain/clear controls.
- The FSM, PC, redirect mux and IF/ID register stay in the top module.

Test Plan:
- Reset release, memory returns addr>>2, no stall → IF/ID pc4 = 4, 8, 0xC, … on consecutive edges from the 3rd edge; instructions 0, 1, 2, ….
- stall_i high for 5 cycles right after a request for 0x10 → skid holds word@0x10, IF/ID frozen, imem_req_o=0. After release: word@0x10 appears, then word@0x14, with no loss or duplicate.
- jump_i with jump_target_i=0x100 mid-stream → if_id_valid_o=0 for 2 edges, then instr@0x100 with pc4=0x104. The word fetched before the redirect never appears.
- jump_i and branch_i together (0x200 / 0x300) while stall_i=1 → PC=0x200, the stall is overridden, instr@0x200 is delivered.
- Edge cases:
  - branch_target_i=0x43 → fetch at 0x40.
  - ADDR_W=8, PC=0xFC → next fetch at 0x00.
  - instr=0x0000_8001 → imm_sext=0xFFFF_8001.
- rst_n pulsed low mid-stall with skid full → all valid flags 0 immediately. Refetch starts from RESET_PC after BOOT.

Source files
------------

// File: rtl/if_pkg.sv
// ----------------------------------------------------------------------------
// if_pkg -- shared types, constants and helpers for the instruction-fetch stage.
//
// Contents:
//   state_t     : fetch control state {BOOT, RUN, REDIR}
//   PC_STEP     : byte distance between consecutive instructions
//   ALIGN_MASK  : low PC bits forced to zero on a redirect (word alignment)
//   sign_extend : sign-extends a value from a given bit position (up to 64 bits)
// ----------------------------------------------------------------------------
package if_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    RUN   = 2'b01,
    REDIR = 2'b10
  } state_t;

  localparam int unsigned PC_STEP    = 32'd4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // Replicates bit sign_pos into every bit above it; bits at and below
  // sign_pos pass through. Callers narrow the 64-bit result to their width.
  function automatic logic [63:0] sign_extend(input logic [63:0] value,
                                              input logic [5:0]  sign_pos);
    logic [63:0] upper;
    logic [63:0] result;
    upper = {64{1'b1}} << (7'(sign_pos) + 7'd1);
    if (value[sign_pos]) begin
      result = value | upper;
    end else begin
      result = value & ~upper;
    end
    return result;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// ----------------------------------------------------------------------------
// if_skid_buf -- one-entry holding register for a fetched {instr, pc} pair.
// Catches the word returning from memory while decode is stalled so that it
// is not lost.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   load         : capture load_instr/load_pc, entry becomes valid
//   drain        : entry consumed, becomes empty (load wins if both set)
//   clear        : invalidate entry (highest priority, used on redirect)
//   load_instr   : instruction word to capture
//   load_pc      : address of that instruction
//   valid        : entry holds a word
//   instr, pc    : stored word and its address
// ----------------------------------------------------------------------------
module if_skid_buf #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] load_instr,
  input  logic [ADDR_W-1:0]  load_pc,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc
);

  logic               valid_r;
  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pc_r;

  // Entry storage: clear > load > drain > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      instr_r <= {INSTR_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      instr_r <= {INSTR_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
    end else if (load) begin
      valid_r <= 1'b1;
      instr_r <= load_instr;
      pc_r    <= load_pc;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign instr = instr_r;
  assign pc    = pc_r;

endmodule

// File: rtl/instr_fetch_stage.sv
// ----------------------------------------------------------------------------
// instr_fetch_stage -- instruction-fetch stage of a MIPS-style pipeline.
// Drives a synchronous 1-cycle-latency instruction memory and registers the
// returned word into the IF/ID pipeline register. Supports decode stall (with
// a one-entry skid buffer), and jump/branch redirect with flush.
//
// Optional feature: define FETCH_PERF_EN to add perf_fetch_cnt_o and
// perf_bubble_cnt_o saturating performance counters.
//
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   stall_i             : decode cannot accept; IF/ID holds
//   jump_i/jump_target_i     : jump redirect (wins over branch)
//   branch_i/branch_target_i : taken-branch redirect
//   imem_req_o/imem_addr_o   : memory read strobe and address (= PC)
//   imem_rdata_i        : read data, valid the cycle after the request
//   if_id_valid_o       : IF/ID holds a live instruction
//   if_id_instr_o       : fetched instruction
//   if_id_pc4_o         : instruction address + 4
//   if_id_imm_sext_o    : sign-extended instr[IMM_W-1:0]
//   pc_debug_o          : current PC register
//   perf_fetch_cnt_o    : (FETCH_PERF_EN) valid IF/ID loads
//   perf_bubble_cnt_o   : (FETCH_PERF_EN) unstalled edges leaving IF/ID empty
// ----------------------------------------------------------------------------
module instr_fetch_stage
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter int                IMM_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               jump_i,
  input  logic [ADDR_W-1:0]  jump_target_i,
  input  logic               branch_i,
  input  logic [ADDR_W-1:0]  branch_target_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic               if_id_valid_o,
  output logic [INSTR_W-1:0] if_id_instr_o,
  output logic [ADDR_W-1:0]  if_id_pc4_o,
  output logic [INSTR_W-1:0] if_id_imm_sext_o,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetch_cnt_o,
  output logic [31:0]        perf_bubble_cnt_o,
`endif
  output logic [ADDR_W-1:0]  pc_debug_o
);

  // Control state and PC
  state_t             state_r;
  state_t             state_nxt_s;
  logic [ADDR_W-1:0]  pc_r;
  logic [ADDR_W-1:0]  pc_nxt_s;

  // F2 tag: a request issued last cycle whose data is on imem_rdata_i now
  logic               f2_valid_r;
  logic [ADDR_W-1:0]  f2_pc_r;

  // IF/ID pipeline register
  logic               if_id_valid_r;
  logic [INSTR_W-1:0] if_id_instr_r;
  logic [ADDR_W-1:0]  if_id_pc4_r;
  logic [INSTR_W-1:0] if_id_imm_r;

  // Redirect / issue decode
  logic               redirect_s;
  logic [ADDR_W-1:0]  target_raw_s;
  logic [ADDR_W-1:0]  target_s;
  logic               issue_s;

  // IF/ID load path
  logic               ifid_load_s;
  logic               ifid_valid_nxt_s;
  logic [INSTR_W-1:0] ld_instr_s;
  logic [ADDR_W-1:0]  ld_pc_s;
  logic [INSTR_W-1:0] ld_imm_s;

  // Skid buffer controls and contents
  logic               skid_load_s;
  logic               skid_drain_s;
  logic               skid_clear_s;
  logic               skid_valid_s;
  logic [INSTR_W-1:0] skid_instr_s;
  logic [ADDR_W-1:0]  skid_pc_s;

  // Redirect target selection, request issue and next state/PC.
  always_comb begin
    redirect_s = jump_i | branch_i;
    if (jump_i) begin
      target_raw_s = jump_target_i;
    end else begin
      target_raw_s = branch_target_i;
    end
    target_s = target_raw_s & ~ADDR_W'(ALIGN_MASK);

    // REDIR issues at the target regardless of stall; a stall only takes
    // effect once back in RUN.
    issue_s     = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      BOOT: begin
        issue_s     = 1'b0;
        state_nxt_s = RUN;
      end
      RUN: begin
        issue_s     = ~redirect_s & ~stall_i;
        state_nxt_s = RUN;
      end
      REDIR: begin
        issue_s     = ~redirect_s;
        state_nxt_s = RUN;
      end
      default: begin
        issue_s     = 1'b0;
        state_nxt_s = BOOT;
      end
    endcase
    if (redirect_s) begin
      state_nxt_s = REDIR;
    end else begin
      state_nxt_s = state_nxt_s;
    end

    if (redirect_s) begin
      pc_nxt_s = target_s;
    end else if (issue_s) begin
      pc_nxt_s = pc_r + ADDR_W'(PC_STEP);
    end else begin
      pc_nxt_s = pc_r;
    end
  end

  // IF/ID source selection: skid first (it is older), then F2 data, else bubble.
  always_comb begin
    ifid_load_s      = 1'b0;
    ifid_valid_nxt_s = if_id_valid_r;
    ld_instr_s       = imem_rdata_i;
    ld_pc_s          = f2_pc_r;
    skid_load_s      = 1'b0;
    skid_drain_s     = 1'b0;
    skid_clear_s     = 1'b0;
    if (redirect_s) begin
      // Flush: in-flight F2 data and any skid word are discarded.
      ifid_valid_nxt_s = 1'b0;
      skid_clear_s     = 1'b1;
    end else if (stall_i) begin
      ifid_valid_nxt_s = if_id_valid_r;
      skid_load_s      = f2_valid_r;
    end else if (skid_valid_s) begin
      ifid_load_s      = 1'b1;
      ifid_valid_nxt_s = 1'b1;
      ld_instr_s       = skid_instr_s;
      ld_pc_s          = skid_pc_s;
      skid_drain_s     = 1'b1;
      skid_load_s      = f2_valid_r;
    end else if (f2_valid_r) begin
      ifid_load_s      = 1'b1;
      ifid_valid_nxt_s = 1'b1;
    end else begin
      ifid_valid_nxt_s = 1'b0;
    end
    ld_imm_s = INSTR_W'(sign_extend(64'(ld_instr_s), 6'(IMM_W - 1)));
  end

  if_skid_buf #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load_s),
    .drain      (skid_drain_s),
    .clear      (skid_clear_s),
    .load_instr (imem_rdata_i),
    .load_pc    (f2_pc_r),
    .valid      (skid_valid_s),
    .instr      (skid_instr_s),
    .pc         (skid_pc_s)
  );

  // FSM state, PC and F2 tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= BOOT;
      pc_r       <= RESET_PC;
      f2_valid_r <= 1'b0;
      f2_pc_r    <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      pc_r       <= pc_nxt_s;
      f2_valid_r <= issue_s;
      if (issue_s) begin
        f2_pc_r <= pc_r;
      end else begin
        f2_pc_r <= f2_pc_r;
      end
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_valid_r <= 1'b0;
      if_id_instr_r <= {INSTR_W{1'b0}};
      if_id_pc4_r   <= {ADDR_W{1'b0}};
      if_id_imm_r   <= {INSTR_W{1'b0}};
    end else begin
      if_id_valid_r <= ifid_valid_nxt_s;
      if (ifid_load_s) begin
        if_id_instr_r <= ld_instr_s;
        if_id_pc4_r   <= ld_pc_s + ADDR_W'(PC_STEP);
        if_id_imm_r   <= ld_imm_s;
      end else begin
        if_id_instr_r <= if_id_instr_r;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_r;
  logic [31:0] perf_bubble_r;

  // Saturating fetch / bubble counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_r  <= 32'd0;
      perf_bubble_r <= 32'd0;
    end else begin
      if (ifid_load_s && (perf_fetch_r != 32'hFFFF_FFFF)) begin
        perf_fetch_r <= perf_fetch_r + 32'd1;
      end else begin
        perf_fetch_r <= perf_fetch_r;
      end
      if (!stall_i && !ifid_valid_nxt_s && (perf_bubble_r != 32'hFFFF_FFFF)) begin
        perf_bubble_r <= perf_bubble_r + 32'd1;
      end else begin
        perf_bubble_r <= perf_bubble_r;
      end
    end
  end

  assign perf_fetch_cnt_o  = perf_fetch_r;
  assign perf_bubble_cnt_o = perf_bubble_r;
`endif

  // The request strobe must drop in the same cycle stall_i or a redirect
  // arrives, so it is decoded from registered state plus those inputs.
  assign imem_req_o       = issue_s;
  assign imem_addr_o      = pc_r;
  assign if_id_valid_o    = if_id_valid_r;
  assign if_id_instr_o    = if_id_instr_r;
  assign if_id_pc4_o      = if_id_pc4_r;
  assign if_id_imm_sext_o = if_id_imm_r;
  assign pc_debug_o       = pc_r;

endmodule
